iomem_burst_master: RTL

IOMEM_BURST_MASTER -- requirements
Module: iomem_burst_master

---
 rtl/iomem_burst_master.sv | 136 +++++++++++++
 1 files changed

// File: rtl/iomem_burst_master.sv
// rtl/iomem_burst_master.sv - burst command engine driving a valid/ready iomem bus
// One bus beat at a time, with a mandatory idle cycle between beats and a per-beat ready timeout.
module iomem_burst_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic        cmd_write_i,
  input  logic [3:0]  cmd_wstrb_i,
  input  logic [3:0]  cmd_len_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  output logic        wr_ready_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        iomem_valid_o,
  input  logic        iomem_ready_i,
  output logic [31:0] iomem_addr_o,
  output logic [31:0] iomem_wdata_o,
  output logic [3:0]  iomem_wstrb_o,
  input  logic [31:0] iomem_rdata_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd_data_q;
  logic [3:0]        wstrb_q;
  logic [3:0]        beats_left;
  logic              write_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_valid_q;
  logic              done_q;
  logic              err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rd_data_q  <= 32'd0;
      wstrb_q    <= 4'd0;
      beats_left <= 4'd0;
      write_q    <= 1'b0;
      wait_cnt   <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            addr_q     <= cmd_addr_i & 32'hFFFF_FFFC;
            beats_left <= cmd_len_i;
            write_q    <= cmd_write_i;
            wstrb_q    <= cmd_write_i ? cmd_wstrb_i : 4'b0000;
            wait_cnt   <= '0;
            // A write that would touch no bytes is swallowed and reported as an error.
            if (cmd_write_i && (cmd_wstrb_i == 4'b0000)) begin
              err_q <= 1'b1;
            end else if (cmd_write_i) begin
              state <= S_WDATA;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_WDATA: begin
          if (wr_valid_i) begin
            wdata_q  <= wr_data_i;
            wait_cnt <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (iomem_ready_i) begin
            if (!write_q) begin
              rd_data_q  <= iomem_rdata_i;
              rd_valid_q <= 1'b1;
            end
            if (beats_left == 4'd0) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              addr_q     <= addr_q + 32'd4;
              beats_left <= beats_left - 4'd1;
              state      <= S_GAP;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Ready wins over timeout, so this branch only sees a beat that never completed.
            err_q    <= 1'b1;
            wait_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_GAP: begin
          wait_cnt <= '0;
          state    <= write_q ? S_WDATA : S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = (state == S_IDLE);
  assign wr_ready_o    = (state == S_WDATA);
  assign busy_o        = (state != S_IDLE);
  assign iomem_valid_o = (state == S_REQ);
  assign iomem_addr_o  = addr_q;
  assign iomem_wdata_o = wdata_q;
  assign iomem_wstrb_o = wstrb_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule
